// File: rtl/apb_protocol_checker_pkg.sv
// Shared types for the APB3 protocol checker: bus phase encoding, rule indices
// and the helper that picks the reported rule out of a violation vector.
package apb_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_e;

    localparam int R_PEN_NOSEL = 0;
    localparam int R_SETUP     = 1;
    localparam int R_STABLE    = 2;
    localparam int R_ONEHOT    = 3;
    localparam int R_TIMEOUT   = 4;
    localparam int R_SLVERR    = 5;
    localparam int NUM_RULES   = 6;

    typedef logic [NUM_RULES-1:0] rule_vec_t;

    function automatic logic [2:0] lowest_rule(rule_vec_t v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_protocol_checker_if.sv
// APB3 bus segment. A transfer is one SETUP cycle (PSEL set, PENABLE low) followed by
// ACCESS cycles (PENABLE high) until PREADY; select, address, direction and write data hold throughout.
interface apb_protocol_checker_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 1
);
    logic [NUM_SLV-1:0] PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [ADDR_W-1:0]  PADDR;
    logic [DATA_W-1:0]  PWDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PSLVERR
    );

    modport monitor (
        input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_protocol_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment in the clear cycle
// is applied on top of the cleared value.
module apb_chk_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] base;

    always_comb begin
        base = clr ? '0 : count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (base != '1)) begin
            count <= base + W'(1);
        end else begin
            count <= base;
        end
    end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB3 protocol checker: tracks the transfer phase, evaluates six rules each
// cycle and reports sticky status, counters, a first-error capture and an interrupt.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    apb_protocol_checker_if.monitor bus,
    input  rule_vec_t              rule_en_i,
    input  logic                   clr_i,
    output rule_vec_t              err_status_o,
    output logic [CNT_W-1:0]       err_count_o,
    output logic [CNT_W-1:0]       txn_count_o,
    output logic                   first_err_valid_o,
    output logic [2:0]             first_err_code_o,
    output logic                   irq_o,
    output phase_e                 dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    phase_e             state;
    phase_e             ph;
    logic               done;
    logic               settle;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [NUM_SLV-1:0] cap_sel;
    logic [ADDR_W-1:0]  cap_addr;
    logic               cap_write;
    logic [DATA_W-1:0]  cap_wdata;
    rule_vec_t          raw;
    rule_vec_t          v;
    rule_vec_t          status_next;
    logic               first_valid_next;
    logic [2:0]         first_code_next;
    logic               in_xfer;

    assign dbg_state = state;

    always_comb begin
        ph = IDLE;
        if (bus.PSEL != '0) ph = bus.PENABLE ? ACCESS : SETUP;
        done    = (ph == ACCESS) && bus.PREADY;
        in_xfer = (state == SETUP) || (state == ACCESS);

        raw = '0;
        raw[R_PEN_NOSEL] = bus.PENABLE && (bus.PSEL == '0);
        raw[R_SETUP]     = ((state == SETUP) && (ph != ACCESS)) ||
                           ((state == IDLE) && (ph == ACCESS));
        raw[R_STABLE]    = in_xfer && (ph == ACCESS) &&
                           ((bus.PSEL != cap_sel) || (bus.PADDR != cap_addr) ||
                            (bus.PWRITE != cap_write) ||
                            (bus.PWRITE && (bus.PWDATA != cap_wdata)));
        raw[R_ONEHOT]    = (bus.PSEL & (bus.PSEL - NUM_SLV'(1))) != '0;
        raw[R_TIMEOUT]   = (ph == ACCESS) && !bus.PREADY &&
                           (wait_cnt == WAIT_W'(TIMEOUT - 1));
        raw[R_SLVERR]    = bus.PSLVERR && !done;

        // The cycle after reset sees a bus that may still be mid-transfer; stay silent.
        v = settle ? '0 : (raw & rule_en_i);

        status_next = (clr_i ? '0 : err_status_o) | v;

        first_valid_next = clr_i ? 1'b0 : first_err_valid_o;
        first_code_next  = clr_i ? 3'd0 : first_err_code_o;
        if (!first_valid_next && (v != '0)) begin
            first_valid_next = 1'b1;
            first_code_next  = lowest_rule(v);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state             <= IDLE;
            settle            <= 1'b1;
            wait_cnt          <= '0;
            cap_sel           <= '0;
            cap_addr          <= '0;
            cap_write         <= 1'b0;
            cap_wdata         <= '0;
            err_status_o      <= '0;
            first_err_valid_o <= 1'b0;
            first_err_code_o  <= 3'd0;
            irq_o             <= 1'b0;
        end else begin
            settle <= 1'b0;
            state  <= done ? IDLE : ph;
            if ((ph == ACCESS) && !bus.PREADY) begin
                wait_cnt <= (wait_cnt == WAIT_W'(TIMEOUT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (ph == SETUP) begin
                cap_sel   <= bus.PSEL;
                cap_addr  <= bus.PADDR;
                cap_write <= bus.PWRITE;
                cap_wdata <= bus.PWDATA;
            end
            err_status_o      <= status_next;
            irq_o             <= |status_next;
            first_err_valid_o <= first_valid_next;
            first_err_code_o  <= first_code_next;
        end
    end

    apb_chk_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (PCLK),
        .rst   (PRESET),
        .clr   (clr_i),
        .inc   (v != '0),
        .count (err_count_o)
    );

    apb_chk_sat_cnt #(.W(CNT_W)) u_txn_cnt (
        .clk   (PCLK),
        .rst   (PRESET),
        .clr   (clr_i),
        .inc   (done && !settle),
        .count (txn_count_o)
    );

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Bench for apb_protocol_checker: directed scenarios plus random traffic against a
// rule-level reference model; a second instance with 2-bit counters shares the bus.
module tb_apb_protocol_checker;
    import apb_chk_pkg::*;

    localparam int TIMEOUT = 4;

    logic      PCLK = 1'b0;
    logic      PRESET;
    rule_vec_t rule_en;
    logic      clr;

    always #5 PCLK = ~PCLK;

    apb_protocol_checker_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(2)) bus ();

    rule_vec_t   status_a, status_b;
    logic [15:0] err_a, txn_a;
    logic [1:0]  err_b, txn_b;
    logic        fev_a, fev_b, irq_a, irq_b;
    logic [2:0]  fec_a, fec_b;
    phase_e      dbg_a, dbg_b;

    apb_protocol_checker #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(2), .TIMEOUT(TIMEOUT), .CNT_W(16)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .rule_en_i(rule_en), .clr_i(clr),
        .err_status_o(status_a), .err_count_o(err_a), .txn_count_o(txn_a),
        .first_err_valid_o(fev_a), .first_err_code_o(fec_a), .irq_o(irq_a), .dbg_state(dbg_a)
    );

    apb_protocol_checker #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(2), .TIMEOUT(TIMEOUT), .CNT_W(2)) u_dut_small (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .rule_en_i(rule_en), .clr_i(clr),
        .err_status_o(status_b), .err_count_o(err_b), .txn_count_o(txn_b),
        .first_err_valid_o(fev_b), .first_err_code_o(fec_b), .irq_o(irq_b), .dbg_state(dbg_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase history, last SETUP values, and plain integer counts.
    int          m_prev_ph;
    bit          m_prev_done;
    bit          m_settle;
    int          m_wait;
    logic [5:0]  m_status;
    int          m_err, m_txn;
    bit          m_fev;
    int          m_fec;
    logic [1:0]  c_sel;
    logic [31:0] c_addr, c_wdata;
    logic        c_write;

    function automatic int sat(int c, int max);
        return (c > max) ? max : c;
    endfunction

    task automatic model_step();
        int ph;
        bit done, in_xfer;
        logic [5:0] raw, v;
        if (PRESET) begin
            m_status = '0; m_err = 0; m_txn = 0; m_fev = 0; m_fec = 0; m_wait = 0;
            m_prev_ph = 0; m_prev_done = 0; m_settle = 1;
            c_sel = '0; c_addr = '0; c_write = 0; c_wdata = '0;
            return;
        end
        ph      = (bus.PSEL == 0) ? 0 : (bus.PENABLE ? 2 : 1);
        done    = (ph == 2) && bus.PREADY;
        in_xfer = (m_prev_ph == 1) || (m_prev_ph == 2 && !m_prev_done);
        raw     = '0;
        raw[0]  = bus.PENABLE && (bus.PSEL == 0);
        raw[1]  = (m_prev_ph == 1 && ph != 2) || (!in_xfer && ph == 2);
        raw[2]  = in_xfer && ph == 2 && (bus.PSEL != c_sel || bus.PADDR != c_addr ||
                  bus.PWRITE != c_write || (bus.PWRITE && bus.PWDATA != c_wdata));
        raw[3]  = $countones(bus.PSEL) > 1;
        raw[4]  = (ph == 2) && !bus.PREADY && (m_wait == TIMEOUT - 1);
        raw[5]  = bus.PSLVERR && !done;
        if (ph == 2 && !bus.PREADY) m_wait = (m_wait + 1 > TIMEOUT) ? TIMEOUT : m_wait + 1;
        else m_wait = 0;
        v = m_settle ? 6'b0 : (raw & rule_en);
        if (clr) begin
            m_status = '0; m_err = 0; m_txn = 0; m_fev = 0; m_fec = 0;
        end
        m_status = m_status | v;
        if (v != 0) m_err++;
        if (done && !m_settle) m_txn++;
        if (!m_fev && v != 0) begin
            for (int i = 5; i >= 0; i--) if (v[i]) m_fec = i;
            m_fev = 1;
        end
        if (ph == 1) begin
            c_sel = bus.PSEL; c_addr = bus.PADDR; c_write = bus.PWRITE; c_wdata = bus.PWDATA;
        end
        m_prev_ph = ph; m_prev_done = done; m_settle = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_idle();
        bus.PSEL = '0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0;
        bus.PWDATA = '0; bus.PREADY = 0; bus.PSLVERR = 0;
    endtask

    task automatic do_clr();
        set_idle();
        tick();
        clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic apb_xfer(input logic [1:0] sel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input int waits);
        bus.PSEL = sel; bus.PENABLE = 0; bus.PWRITE = wr; bus.PADDR = addr;
        bus.PWDATA = data; bus.PREADY = 0; bus.PSLVERR = 0;
        tick();
        bus.PENABLE = 1;
        for (int i = 0; i < waits; i++) tick();
        bus.PREADY = 1;
        tick();
    endtask

    task automatic test_reset();
        PRESET = 1; clr = 0; rule_en = '1;
        set_idle();
        tick();
        tick();
        total++; if (status_a !== 6'b0) begin bad++; $display("FAIL reset_status got=%b exp=0", status_a); end
        total++; if (err_a !== 16'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", err_a); end
        total++; if (txn_a !== 16'd0) begin bad++; $display("FAIL reset_txn got=%0d exp=0", txn_a); end
        total++; if ({fev_a, fec_a, irq_a} !== 5'b0) begin bad++; $display("FAIL reset_capirq got=%b exp=0", {fev_a, fec_a, irq_a}); end
        total++; if (dbg_a !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_a); end
        total++; if (err_b !== 2'd0) begin bad++; $display("FAIL reset_err_small got=%0d exp=0", err_b); end
        PRESET = 0;
        tick();
    endtask

    task automatic test_legal_write();
        do_clr();
        apb_xfer(2'b01, 1'b1, 32'h10, 32'hA5, 2);
        set_idle();
        total++; if (txn_a !== 16'd1) begin bad++; $display("FAIL t1_txn got=%0d exp=1", txn_a); end
        total++; if (status_a !== 6'b0) begin bad++; $display("FAIL t1_status got=%b exp=0", status_a); end
        total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL t1_irq got=%b exp=0", irq_a); end
    endtask

    task automatic test_pen_nosel();
        do_clr();
        bus.PENABLE = 1;
        tick();
        set_idle();
        total++; if (status_a !== 6'b000001) begin bad++; $display("FAIL t2_status got=%b exp=000001", status_a); end
        total++; if ({fev_a, fec_a} !== 4'b1000) begin bad++; $display("FAIL t2_code got=%b/%0d exp=1/0", fev_a, fec_a); end
        total++; if (err_a !== 16'd1) begin bad++; $display("FAIL t2_err got=%0d exp=1", err_a); end
        total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL t2_irq got=%b exp=1", irq_a); end
    endtask

    task automatic addr_glitch();
        bus.PSEL = 2'b01; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h10; bus.PWDATA = 32'h55;
        bus.PREADY = 0; bus.PSLVERR = 0;
        tick();
        bus.PENABLE = 1;
        tick();
        bus.PADDR = 32'h14;
        tick();
        bus.PREADY = 1;
        tick();
        set_idle();
    endtask

    task automatic test_stable();
        do_clr();
        addr_glitch();
        total++; if (status_a !== 6'b000100) begin bad++; $display("FAIL t3_status got=%b exp=000100", status_a); end
        total++; if ({fec_a, err_a} !== {3'd2, 16'd2}) begin bad++; $display("FAIL t3_code_err got=%0d/%0d exp=2/2", fec_a, err_a); end
        do_clr();
        rule_en = 6'b111011;
        addr_glitch();
        total++; if ({status_a, err_a} !== 22'd0) begin bad++; $display("FAIL t3_disabled got=%b/%0d exp=0/0", status_a, err_a); end
        rule_en = '1;
    endtask

    task automatic test_onehot_slverr();
        do_clr();
        bus.PSEL = 2'b11; bus.PSLVERR = 1;
        tick();
        total++; if (status_a !== 6'b101000) begin bad++; $display("FAIL t4_status got=%b exp=101000", status_a); end
        total++; if (fec_a !== 3'd3) begin bad++; $display("FAIL t4_code got=%0d exp=3", fec_a); end
        total++; if (err_a !== 16'd1) begin bad++; $display("FAIL t4_err got=%0d exp=1", err_a); end
        set_idle();
    endtask

    task automatic test_timeout();
        do_clr();
        bus.PSEL = 2'b10; bus.PWRITE = 0; bus.PADDR = 32'h40;
        tick();
        bus.PENABLE = 1;
        for (int i = 0; i < 10; i++) tick();
        total++; if (status_a !== 6'b010000) begin bad++; $display("FAIL t5_status got=%b exp=010000", status_a); end
        total++; if (err_a !== 16'd1) begin bad++; $display("FAIL t5_err got=%0d exp=1", err_a); end
        total++; if (dbg_a !== ACCESS) begin bad++; $display("FAIL t5_state got=%0d exp=2", dbg_a); end
        bus.PREADY = 1;
        tick();
        set_idle();
        total++; if (txn_a !== 16'd1) begin bad++; $display("FAIL t5_txn got=%0d exp=1", txn_a); end
    endtask

    task automatic test_clr_and_sat();
        set_idle();
        tick();
        bus.PENABLE = 1; clr = 1;
        tick();
        clr = 0;
        set_idle();
        total++; if ({status_a, err_a} !== {6'b000001, 16'd1}) begin bad++; $display("FAIL t6_clr got=%b/%0d exp=000001/1", status_a, err_a); end
        total++; if (err_b !== 2'd1) begin bad++; $display("FAIL t6_clr_small got=%0d exp=1", err_b); end
        do_clr();
        bus.PENABLE = 1;
        for (int i = 0; i < 5; i++) tick();
        set_idle();
        total++; if (err_b !== 2'd3) begin bad++; $display("FAIL t6_sat got=%0d exp=3", err_b); end
        total++; if (err_a !== 16'd5) begin bad++; $display("FAIL t6_wide got=%0d exp=5", err_a); end
    endtask

    task automatic test_reset_mid();
        bus.PSEL = 2'b01; bus.PWRITE = 1; bus.PADDR = 32'h8; bus.PWDATA = 32'h3C;
        tick();
        bus.PENABLE = 1;
        tick();
        PRESET = 1;
        tick();
        PRESET = 0;
        tick();
        set_idle();
        tick();
        total++; if ({status_a, fev_a, irq_a} !== 8'd0) begin bad++; $display("FAIL reset_mid_flags got=%b exp=0", {status_a, fev_a, irq_a}); end
        total++; if ({err_a, txn_a} !== 32'd0) begin bad++; $display("FAIL reset_mid_cnt got=%0d/%0d exp=0/0", err_a, txn_a); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        apb_xfer(2'b01, 1'b1, 32'h20, 32'h1234, 1);
        apb_xfer(2'b10, 1'b0, 32'h24, 32'h0, 0);
        set_idle();
        total++; if (txn_a !== 16'd2) begin bad++; $display("FAIL b2b_txn got=%0d exp=2", txn_a); end
        total++; if (status_a !== 6'b0) begin bad++; $display("FAIL b2b_status got=%b exp=0", status_a); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 300; it++) begin
            rule_en = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
            clr     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 7) begin
                apb_xfer(2'b01 << $urandom_range(0, 1), 1'($urandom), {26'd0, 4'($urandom), 2'b00},
                         $urandom, $urandom_range(0, 6));
                if ($urandom_range(0, 1) == 0) begin set_idle(); tick(); end
            end else begin
                bus.PSEL = 2'($urandom); bus.PENABLE = 1'($urandom); bus.PWRITE = 1'($urandom);
                bus.PADDR = {28'd0, 4'($urandom)}; bus.PWDATA = 32'($urandom_range(0, 3));
                bus.PREADY = 1'($urandom); bus.PSLVERR = ($urandom_range(0, 4) == 0);
                tick();
            end
            clr = 0;
            total++; if (status_a !== m_status) begin bad++; $display("FAIL rnd_status it=%0d got=%b exp=%b", it, status_a, m_status); end
            total++; if (err_a !== 16'(sat(m_err, 65535))) begin bad++; $display("FAIL rnd_err it=%0d got=%0d exp=%0d", it, err_a, m_err); end
            total++; if (txn_a !== 16'(sat(m_txn, 65535))) begin bad++; $display("FAIL rnd_txn it=%0d got=%0d exp=%0d", it, txn_a, m_txn); end
            total++; if ({err_b, txn_b} !== {2'(sat(m_err, 3)), 2'(sat(m_txn, 3))}) begin bad++; $display("FAIL rnd_small it=%0d got=%0d/%0d exp=%0d/%0d", it, err_b, txn_b, sat(m_err, 3), sat(m_txn, 3)); end
            total++; if (fev_a !== m_fev || (m_fev && fec_a !== 3'(m_fec))) begin bad++; $display("FAIL rnd_first it=%0d got=%b/%0d exp=%b/%0d", it, fev_a, fec_a, m_fev, m_fec); end
            total++; if (irq_a !== (|m_status)) begin bad++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, irq_a, |m_status); end
        end
    endtask

    initial begin
        PRESET = 1; clr = 0; rule_en = '1;
        set_idle();
        test_reset();
        test_legal_write();
        test_pen_nosel();
        test_stable();
        test_onehot_slverr();
        test_timeout();
        test_clr_and_sat();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
